wb_arbiter_rr: RTL and testbench
================================

WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, default 2, SHALL set the number of Wishbone masters (legal range 2..8).
REQ-002 Parameter aw, default 32, SHALL set the address width.
REQ-003 Parameter dw, default 32, SHALL set the data width; select width is dw/8.
REQ-004 Clocking is fixed: one clock, wb_clk_i; reset is wb_rst_i, synchronous, active-high.
REQ-005 wb_clk_i  in  1  clock; all state SHALL update on its rising edge only.
REQ-006 wb_rst_i  in  1  synchronous active-high reset.
REQ-007 wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i  in  NUM_MASTERS x (aw, dw, dw/8, 1, 1, 1, 3, 2)  packed master requests; master i occupies slice i.
REQ-008 wbm_dat_o  out  dw  slave read data, broadcast to all masters.
REQ-009 wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  per-master termination signals.
REQ-010 wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  aw, dw, dw/8, 1, 1, 1, 3, 2  shared-slave request.
REQ-011 wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  dw, 1, 1, 1  shared-slave response.
REQ-012 grant_o  out  NUM_MASTERS  registered one-hot grant, all-zero when idle.

Function
REQ-013 The arbiter SHALL have two states: IDLE (grant_o == 0) and OWNED (grant_o one-hot).
REQ-014 At each rising edge where state is IDLE, or the owner's wbm_cyc_i is 0, the arbiter SHALL select a new owner from masters with wbm_cyc_i == 1, or go to IDLE if none request.
REQ-015 Selection SHALL be round-robin: search starts at index (last_owner+1) mod NUM_MASTERS and ascends with wrap; the first requester found wins.
REQ-016 last_owner SHALL update only when a new owner is granted.
REQ-017 While OWNED and the owner's wbm_cyc_i == 1, the grant SHALL NOT change, regardless of other requests; bursts (any cti/bte) and multi-access cycles are therefore never split.
REQ-018 All wbs_* request outputs SHALL be a combinational mux of the owner's wbm_* slice; wbs_cyc_o and wbs_stb_o SHALL be 0 when IDLE.
REQ-019 When IDLE, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o and wbs_bte_o SHALL present last_owner's slice.
REQ-020 wbm_ack_o[i], wbm_err_o[i] and wbm_rty_o[i] SHALL equal wbs_ack_i, wbs_err_i and wbs_rty_i ANDed with grant_o[i]; non-owners SHALL see 0.
REQ-021 Arbitration latency SHALL be one cycle: a request raised in cycle t on an idle arbiter appears on wbs_cyc_o in cycle t+1.
REQ-022 Handover SHALL leave exactly one cycle with wbs_cyc_o == 0: the cycle in which the old owner drops cyc; the new owner drives wbs_cyc_o from the next cycle.
REQ-023 A master that drops and re-raises cyc SHALL lose priority to any other pending requester.
REQ-024 An owner dropping cyc with no other requester present SHALL return the arbiter to IDLE, even if the same master re-raises cyc in that same cycle; that master is then granted one cycle later.
REQ-025 Slave responses arriving while IDLE SHALL be dropped and not forwarded.

Reset
REQ-026 On a rising edge with wb_rst_i == 1, grant_o SHALL become 0 and last_owner SHALL become NUM_MASTERS-1, so master 0 wins first.
REQ-027 While wb_rst_i == 1, wbs_cyc_o, wbs_stb_o and all wbm_ack_o, wbm_err_o and wbm_rty_o bits SHALL be forced to 0 combinationally.
REQ-028 Reset asserted mid-burst SHALL abort ownership with no further forwarding; there is no other recovery path.

Verification
REQ-029 Single request: master 1 raises cyc/stb, adr 0x100, we=1 -> grant_o=2'b10 after one edge; wbs_adr_o=0x100; ack reaches master 1 only.
REQ-030 Simultaneous request after reset: masters 0 and 1 both assert cyc -> master 0 granted first; master 1 granted on the edge after master 0 drops cyc, with one wbs_cyc_o==0 cycle between owners.
REQ-031 Fairness: 3 masters continuously requesting, each releasing after one access -> grant order 0,1,2,0,1,2 over 6 ownerships.
REQ-032 Burst lock: master 0 does a 4-beat incrementing burst (cti 3'b010, then 3'b111) while master 1 requests -> all 4 acks go to master 0; master 1 is granted only after master 0 drops cyc.
REQ-033 Reset mid-burst: wb_rst_i asserted after beat 2 -> wbs_cyc_o=0 in the same cycle, grant_o=0 after the edge, and master 0 wins the next arbitration.
REQ-034 Regression: instantiate with two transactor masters sharing one memory model, run random transactions with all read-back checks passing, and confirm grant_o is never non-one-hot.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr
// Round-robin arbiter that lets NUM_MASTERS Wishbone masters share one slave.
// Ownership is held until the owner drops cyc, so bursts are never split.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbm_*_i                     packed master requests, master i in slice i
//   wbm_dat_o                   slave read data, broadcast to every master
//   wbm_ack_o/err_o/rty_o       per-master terminations, gated by grant
//   wbs_*_o                     request of the current owner to the slave
//   wbs_dat_i/ack_i/err_i/rty_i slave response
//   grant_o                     registered one-hot grant, zero when idle
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int aw          = 32,
  parameter int dw          = 32
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0]    wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0]    wbm_dat_i,
  input  logic [NUM_MASTERS*dw/8-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]       wbm_we_i,
  input  logic [NUM_MASTERS-1:0]       wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]       wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]     wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]     wbm_bte_i,
  output logic [dw-1:0]                wbm_dat_o,
  output logic [NUM_MASTERS-1:0]       wbm_ack_o,
  output logic [NUM_MASTERS-1:0]       wbm_err_o,
  output logic [NUM_MASTERS-1:0]       wbm_rty_o,
  output logic [aw-1:0]                wbs_adr_o,
  output logic [dw-1:0]                wbs_dat_o,
  output logic [dw/8-1:0]              wbs_sel_o,
  output logic                         wbs_we_o,
  output logic                         wbs_cyc_o,
  output logic                         wbs_stb_o,
  output logic [2:0]                   wbs_cti_o,
  output logic [1:0]                   wbs_bte_o,
  input  logic [dw-1:0]                wbs_dat_i,
  input  logic                         wbs_ack_i,
  input  logic                         wbs_err_i,
  input  logic                         wbs_rty_i,
  output logic [NUM_MASTERS-1:0]       grant_o
);

  localparam int SW = dw / 8;
  localparam int LW = $clog2(NUM_MASTERS);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  // Doubles as the owner index while OWNED, since it is written on every grant.
  logic [LW-1:0]          r_last_owner;
  logic [LW-1:0]          w_last_nxt;
  logic [LW-1:0]          w_pick;
  logic                   w_found;
  logic                   w_rearb;
  int                     w_owner_idx;

  assign w_owner_idx = int'(r_last_owner);

  // State register: grant, state and round-robin pointer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_grant      <= {NUM_MASTERS{1'b0}};
      r_last_owner <= LAST_RST;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  // Next-state logic: round-robin search from last_owner+1, only when the bus is free
  always_comb begin
    int idx;
    idx     = 32'sd0;
    w_found = 1'b0;
    w_pick  = r_last_owner;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx     = w_owner_idx + k;
      idx     = (idx >= NUM_MASTERS) ? (idx - NUM_MASTERS) : idx;
      // First requester after the previous owner wins; the previous owner is checked last.
      w_pick  = (!w_found && wbm_cyc_i[idx]) ? LW'(idx) : w_pick;
      w_found = w_found | wbm_cyc_i[idx];
    end

    w_rearb = (r_state == ST_IDLE) || !wbm_cyc_i[w_owner_idx];

    if (w_rearb && w_found) begin
      w_state_nxt = ST_OWNED;
      w_grant_nxt = ONE_HOT0 << w_pick;
      w_last_nxt  = w_pick;
    end else if (w_rearb) begin
      w_state_nxt = ST_IDLE;
      w_grant_nxt = {NUM_MASTERS{1'b0}};
      w_last_nxt  = r_last_owner;
    end else begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last_owner;
    end
  end

  // Output decode: owner slice to the slave, responses back to the granted master only
  always_comb begin
    wbs_adr_o = wbm_adr_i[w_owner_idx*aw +: aw];
    wbs_dat_o = wbm_dat_i[w_owner_idx*dw +: dw];
    wbs_sel_o = wbm_sel_i[w_owner_idx*SW +: SW];
    wbs_we_o  = wbm_we_i[w_owner_idx];
    wbs_cti_o = wbm_cti_i[w_owner_idx*3 +: 3];
    wbs_bte_o = wbm_bte_i[w_owner_idx*2 +: 2];
    // Reset forces the handshake low in the same cycle, before grant clears.
    wbs_cyc_o = wbm_cyc_i[w_owner_idx] & (r_state == ST_OWNED) & ~wb_rst_i;
    wbs_stb_o = wbm_stb_i[w_owner_idx] & (r_state == ST_OWNED) & ~wb_rst_i;
    wbm_dat_o = wbs_dat_i;
    // Grant is zero when idle, so stray slave responses go nowhere.
    wbm_ack_o = r_grant & {NUM_MASTERS{wbs_ack_i & ~wb_rst_i}};
    wbm_err_o = r_grant & {NUM_MASTERS{wbs_err_i & ~wb_rst_i}};
    wbm_rty_o = r_grant & {NUM_MASTERS{wbs_rty_i & ~wb_rst_i}};
    grant_o   = r_grant;
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
module tb_wb_arbiter_rr;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   onehot_bad = 0;

  // Per-master drive for the 2-master instance
  logic [31:0] m_adr [N];
  logic [31:0] m_dat [N];
  logic [3:0]  m_sel [N];
  logic        m_we  [N];
  logic        m_cyc [N];
  logic        m_stb [N];
  logic [2:0]  m_cti [N];
  logic [1:0]  m_bte [N];

  logic [63:0] p_adr, p_dat;
  logic [7:0]  p_sel;
  logic [1:0]  p_we, p_cyc, p_stb;
  logic [5:0]  p_cti;
  logic [3:0]  p_bte;

  assign p_adr = {m_adr[1], m_adr[0]};
  assign p_dat = {m_dat[1], m_dat[0]};
  assign p_sel = {m_sel[1], m_sel[0]};
  assign p_we  = {m_we[1],  m_we[0]};
  assign p_cyc = {m_cyc[1], m_cyc[0]};
  assign p_stb = {m_stb[1], m_stb[0]};
  assign p_cti = {m_cti[1], m_cti[0]};
  assign p_bte = {m_bte[1], m_bte[0]};

  // Slave side: directed values or memory model
  logic        mem_mode;
  logic [31:0] t_dat;
  logic        t_ack, t_err, t_rty;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] mem [16];
  logic [31:0] s_dat_in;
  logic        s_ack_in;

  assign s_dat_in = mem_mode ? mem_rdata : t_dat;
  assign s_ack_in = mem_mode ? mem_ack   : t_ack;

  logic [31:0] d_dat_o;
  logic [1:0]  d_ack, d_err, d_rty, d_grant;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;

  wb_arbiter_rr #(.NUM_MASTERS(2), .aw(32), .dw(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(p_adr), .wbm_dat_i(p_dat), .wbm_sel_i(p_sel), .wbm_we_i(p_we),
    .wbm_cyc_i(p_cyc), .wbm_stb_i(p_stb), .wbm_cti_i(p_cti), .wbm_bte_i(p_bte),
    .wbm_dat_o(d_dat_o), .wbm_ack_o(d_ack), .wbm_err_o(d_err), .wbm_rty_o(d_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(s_dat_in), .wbs_ack_i(s_ack_in), .wbs_err_i(t_err), .wbs_rty_i(t_rty),
    .grant_o(d_grant)
  );

  // 3-master instance for the fairness scenario
  logic [2:0]  d3_cyc;
  logic        d3_sack;
  logic [31:0] d3_dat_o, s3_adr, s3_dat;
  logic [2:0]  d3_ack, d3_err, d3_rty, d3_grant, s3_cti;
  logic [3:0]  s3_sel;
  logic        s3_we, s3_cyc, s3_stb;
  logic [1:0]  s3_bte;

  wb_arbiter_rr #(.NUM_MASTERS(3), .aw(32), .dw(32)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i({96{1'b0}}), .wbm_dat_i({96{1'b0}}), .wbm_sel_i({12{1'b1}}), .wbm_we_i(3'b000),
    .wbm_cyc_i(d3_cyc), .wbm_stb_i(d3_cyc), .wbm_cti_i(9'd0), .wbm_bte_i(6'd0),
    .wbm_dat_o(d3_dat_o), .wbm_ack_o(d3_ack), .wbm_err_o(d3_err), .wbm_rty_o(d3_rty),
    .wbs_adr_o(s3_adr), .wbs_dat_o(s3_dat), .wbs_sel_o(s3_sel), .wbs_we_o(s3_we),
    .wbs_cyc_o(s3_cyc), .wbs_stb_o(s3_stb), .wbs_cti_o(s3_cti), .wbs_bte_o(s3_bte),
    .wbs_dat_i(32'd0), .wbs_ack_i(d3_sack), .wbs_err_i(1'b0), .wbs_rty_i(1'b0),
    .grant_o(d3_grant)
  );

  always #5 clk = ~clk;

  // Memory slave: single-cycle registered ack, word addressed by adr[5:2]
  always @(posedge clk) begin
    if (rst || !mem_mode) begin
      mem_ack <= 1'b0;
    end else if (s_cyc && s_stb && !mem_ack) begin
      mem_ack <= 1'b1;
      if (s_we) mem[s_adr[5:2]] <= s_dat;
      mem_rdata <= mem[s_adr[5:2]];
    end else begin
      mem_ack <= 1'b0;
    end
  end

  // Grant must be zero or one-hot on every cycle of both instances
  always @(negedge clk) begin
    if (!rst && (((d_grant & (d_grant - 2'd1)) != 2'd0) || ((d3_grant & (d3_grant - 3'd1)) != 3'd0)))
      onehot_bad++;
  end

  task automatic drop(input int m);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_cti[m] = 3'b000;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_adr[0] = 32'h0000_5555; m_adr[1] = 32'h0000_AAAA;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    t_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (d_grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", d_grant); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc got %b exp 0", s_cyc); end
    checks++; if (d_ack !== 2'b00) begin errors++; $display("FAIL rst_ack got %b exp 00", d_ack); end
    checks++; if (d3_grant !== 3'b000) begin errors++; $display("FAIL rst_grant3 got %b exp 000", d3_grant); end
    drop(0); drop(1); t_ack = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (s_adr !== 32'h0000_AAAA) begin errors++; $display("FAIL idle_last_slice got %h exp 0000aaaa", s_adr); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL idle_stb got %b exp 0", s_stb); end
  endtask

  task automatic test_single;
    m_adr[1] = 32'h0000_0100; m_dat[1] = 32'h0000_1234; m_we[1] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", s_cyc); end
    @(negedge clk);
    checks++; if (d_grant !== 2'b10) begin errors++; $display("FAIL single_grant got %b exp 10", d_grant); end
    checks++; if ({s_adr, s_we, s_cyc, s_stb} !== {32'h0000_0100, 3'b111}) begin
      errors++; $display("FAIL single_req got adr %h we %b cyc %b stb %b exp 100 1 1 1", s_adr, s_we, s_cyc, s_stb); end
    checks++; if (s_dat !== 32'h0000_1234) begin errors++; $display("FAIL single_wdat got %h exp 00001234", s_dat); end
    t_ack = 1'b1; t_err = 1'b1; t_rty = 1'b1; t_dat = 32'hCAFE_F00D;
    #1;
    checks++; if ({d_ack, d_err, d_rty} !== 6'b10_10_10) begin
      errors++; $display("FAIL single_term got ack %b err %b rty %b exp 10 10 10", d_ack, d_err, d_rty); end
    checks++; if (d_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_rdat got %h exp cafef00d", d_dat_o); end
    @(negedge clk);
    t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; drop(1);
    @(negedge clk);
    checks++; if (d_grant !== 2'b00) begin errors++; $display("FAIL single_idle got %b exp 00", d_grant); end
    t_ack = 1'b1;
    #1;
    checks++; if (d_ack !== 2'b00) begin errors++; $display("FAIL idle_drop_ack got %b exp 00", d_ack); end
    t_ack = 1'b0;
  endtask

  task automatic test_idle_return;
    @(negedge clk); m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);
    checks++; if (d_grant !== 2'b10) begin errors++; $display("FAIL ret_grant got %b exp 10", d_grant); end
    drop(1);
    @(negedge clk);
    checks++; if (d_grant !== 2'b00) begin errors++; $display("FAIL ret_idle got %b exp 00", d_grant); end
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL ret_cyc got %b exp 0", s_cyc); end
    @(negedge clk);
    checks++; if (d_grant !== 2'b10) begin errors++; $display("FAIL ret_regrant got %b exp 10", d_grant); end
    drop(1);
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);
    checks++; if (d_grant !== 2'b01) begin errors++; $display("FAIL simul_first got %b exp 01", d_grant); end
    @(negedge clk);
    checks++; if (d_grant !== 2'b01) begin errors++; $display("FAIL simul_hold got %b exp 01", d_grant); end
    drop(0);
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL simul_gap got %b exp 0", s_cyc); end
    @(negedge clk);
    checks++; if ({d_grant, s_cyc} !== 3'b10_1) begin errors++; $display("FAIL simul_second got grant %b cyc %b exp 10 1", d_grant, s_cyc); end
    drop(1);
    @(negedge clk);
  endtask

  task automatic test_burst;
    m_adr[0] = 32'h0000_0200; m_cti[0] = 3'b010; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clk);
    checks++; if (d_grant !== 2'b01) begin errors++; $display("FAIL burst_grant got %b exp 01", d_grant); end
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_adr[0] = 32'h0000_0200 + 32'(4 * b);
      m_cti[0] = (b == 3) ? 3'b111 : 3'b010;
      t_ack = 1'b1;
      #1;
      checks++; if ({d_ack, d_grant, s_cti} !== {2'b01, 2'b01, m_cti[0]}) begin
        errors++; $display("FAIL burst_beat%0d got ack %b grant %b cti %b exp 01 01 %b", b, d_ack, d_grant, s_cti, m_cti[0]); end
      @(negedge clk);
    end
    t_ack = 1'b0; drop(0);
    #1;
    checks++; if ({d_grant, s_cyc} !== 3'b01_0) begin errors++; $display("FAIL burst_release got grant %b cyc %b exp 01 0", d_grant, s_cyc); end
    @(negedge clk);
    checks++; if (d_grant !== 2'b10) begin errors++; $display("FAIL burst_next got %b exp 10", d_grant); end
    drop(1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    m_cti[0] = 3'b010; m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);
    checks++; if (d_grant !== 2'b01) begin errors++; $display("FAIL rmb_grant got %b exp 01", d_grant); end
    for (int b = 0; b < 2; b++) begin
      t_ack = 1'b1;
      #1;
      checks++; if (d_ack !== 2'b01) begin errors++; $display("FAIL rmb_beat%0d got %b exp 01", b, d_ack); end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++; if ({s_cyc, s_stb, d_ack} !== 4'b0000) begin
      errors++; $display("FAIL rmb_force got cyc %b stb %b ack %b exp 0 0 00", s_cyc, s_stb, d_ack); end
    @(negedge clk);
    checks++; if (d_grant !== 2'b00) begin errors++; $display("FAIL rmb_cleared got %b exp 00", d_grant); end
    rst = 1'b0; t_ack = 1'b0;
    @(negedge clk);
    checks++; if (d_grant !== 2'b01) begin errors++; $display("FAIL rmb_rearb got %b exp 01", d_grant); end
    drop(0); drop(1);
    @(negedge clk);
  endtask

  task automatic test_fairness;
    logic [2:0] exp_g;
    d3_cyc = 3'b111;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      checks++; if (d3_grant !== exp_g) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", k, d3_grant, exp_g); end
      d3_sack = 1'b1;
      #1;
      checks++; if (d3_ack !== exp_g) begin errors++; $display("FAIL fair_ack%0d got %b exp %b", k, d3_ack, exp_g); end
      @(negedge clk);
      d3_sack = 1'b0; d3_cyc = 3'b111 & ~exp_g;
      #1;
      checks++; if (s3_cyc !== 1'b0) begin errors++; $display("FAIL fair_gap%0d got %b exp 0", k, s3_cyc); end
      @(negedge clk);
      d3_cyc = 3'b111;
    end
    d3_cyc = 3'b000;
    @(negedge clk);
  endtask

  task automatic wb_xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdat, output logic ok);
    @(negedge clk);
    m_adr[m] = adr; m_dat[m] = dat; m_we[m] = we; m_sel[m] = 4'hF;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    ok = 1'b0; rdat = 32'd0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (d_ack[m]) begin
        rdat = d_dat_o; ok = 1'b1;
        break;
      end
    end
    drop(m);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL regr_timeout m%0d adr %h got no ack exp ack", m, adr); end
  endtask

  task automatic run_master(input int m, input int n);
    logic [31:0] a, d, r;
    logic ok;
    for (int i = 0; i < n; i++) begin
      a = 32'(m * 32 + 4 * int'($urandom_range(0, 7)));
      d = $urandom;
      wb_xfer(m, 1'b1, a, d, r, ok);
      wb_xfer(m, 1'b0, a, 32'd0, r, ok);
      checks++; if (r !== d) begin errors++; $display("FAIL regr_readback m%0d adr %h got %h exp %h", m, a, r, d); end
    end
  endtask

  task automatic test_regression;
    mem_mode = 1'b1;
    fork
      run_master(0, 12);
      run_master(1, 12);
    join
    mem_mode = 1'b0;
    @(negedge clk);
    checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL grant_onehot got %0d bad cycles exp 0", onehot_bad); end
  endtask

  initial begin
    rst = 1'b1; mem_mode = 1'b0;
    t_dat = 32'd0; t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0;
    d3_cyc = 3'b000; d3_sack = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_adr[i] = 32'd0; m_dat[i] = 32'd0; m_sel[i] = 4'hF; m_bte[i] = 2'b00;
      drop(i);
    end
    @(negedge clk);
    test_reset;
    test_single;
    test_idle_return;
    test_simultaneous;
    test_burst;
    test_reset_mid_burst;
    test_fairness;
    test_regression;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
